// File: rtl/motor_pwm_pkg.sv
// Shared types and helpers for the differential-drive PWM stage.
// Combinational functions only. No clocked logic and no backpressure.
package motor_pwm_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } motor_state_t;

    // Extra bits so base +/- control cannot overflow before saturation.
    localparam int MIX_GUARD = 2;

    function automatic logic [31:0] sat_duty(input logic signed [31:0] t, input int dw);
        logic [31:0] mag;
        logic [31:0] lim;
        lim = (32'd1 << dw) - 32'd1;
        mag = t[31] ? 32'(-t) : 32'(t);
        return (mag > lim) ? lim : mag;
    endfunction

    function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] step);
        if (tgt > cur) begin
            return (tgt - cur > step) ? cur + step : tgt;
        end
        return (cur - tgt > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/motor_channel.sv
// One wheel: RUN/DEAD reversal FSM, dead-time counter, optional slew (MOTOR_PWM_SLEW_EN), comparator.
// Duty/dir update on the clk of a period start; pwm is combinational from registers; no backpressure.
module motor_channel
    import motor_pwm_pkg::*;
#(
    parameter int DUTY_WIDTH   = 8,
    parameter int DEAD_PERIODS = 2,
    parameter int SLEW_STEP    = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  en_i,
    input  logic                  period_start_i,
    input  logic [DUTY_WIDTH-1:0] cnt_i,
    input  logic                  req_dir_i,
    input  logic [DUTY_WIDTH-1:0] req_mag_i,
    output logic                  pwm_o,
    output logic                  dir_o,
    output logic [DUTY_WIDTH-1:0] duty_o
);

`ifdef MOTOR_PWM_SLEW_EN
    localparam bit SLEW_EN = 1'b1;
`else
    localparam bit SLEW_EN = 1'b0;
`endif
    // Without slew a step wider than full scale makes every move a direct jump.
    localparam logic [31:0] STEP = SLEW_EN ? 32'(SLEW_STEP) : (32'd1 << DUTY_WIDTH);
    localparam int DCW = $clog2(DEAD_PERIODS + 1);

    motor_state_t          state_q;
    logic [DCW-1:0]        dead_q;
    logic                  dir_q;
    logic [DUTY_WIDTH-1:0] duty_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= RUN;
            dead_q  <= '0;
            dir_q   <= 1'b0;
            duty_q  <= '0;
        end else if (!en_i) begin
            state_q <= RUN;
            dead_q  <= '0;
            duty_q  <= '0;
        end else if (period_start_i) begin
            case (state_q)
                RUN: begin
                    if (req_mag_i == '0 || req_dir_i == dir_q) begin
                        duty_q <= DUTY_WIDTH'(step_toward(32'(duty_q), 32'(req_mag_i), STEP));
                    end else if (32'(duty_q) <= STEP) begin
                        // Ramp-down finishes this period: the dead time starts now.
                        duty_q  <= '0;
                        dead_q  <= DCW'(DEAD_PERIODS);
                        state_q <= DEAD;
                    end else begin
                        duty_q <= DUTY_WIDTH'(32'(duty_q) - STEP);
                    end
                end
                DEAD: begin
                    if (dead_q == DCW'(1)) begin
                        dir_q   <= req_dir_i;
                        duty_q  <= DUTY_WIDTH'(step_toward(32'd0, 32'(req_mag_i), STEP));
                        state_q <= RUN;
                    end else begin
                        dead_q <= dead_q - DCW'(1);
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign pwm_o  = (state_q == RUN) && (cnt_i < duty_q);
    assign dir_o  = dir_q;
    assign duty_o = duty_q;

endmodule

// File: rtl/motor_pwm_mixer.sv
// Mixes PID correction with base speed into two saturated PWM channels (slew option: MOTOR_PWM_SLEW_EN).
// Sample to target 2 clk, target applied at next period start; accepts every sample, no backpressure.
module motor_pwm_mixer
    import motor_pwm_pkg::*;
#(
    parameter int CONTROL_WIDTH = 16,
    parameter int DUTY_WIDTH    = 8,
    parameter int CTRL_SHIFT    = 0,
    parameter int DEAD_PERIODS  = 2,
    parameter int SLEW_STEP     = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            clk_en_i,
    input  logic                            en_i,
    input  logic signed [CONTROL_WIDTH-1:0] control_in_i,
    input  logic                            control_valid_i,
    input  logic        [DUTY_WIDTH-1:0]    base_speed_i,
    output logic                            pwm_left_o,
    output logic                            pwm_right_o,
    output logic                            dir_left_o,
    output logic                            dir_right_o,
    output logic                            period_start_o,
    output logic        [DUTY_WIDTH-1:0]    duty_left_o,
    output logic        [DUTY_WIDTH-1:0]    duty_right_o
);

    localparam int MIX_W = CONTROL_WIDTH + MIX_GUARD;

    logic [DUTY_WIDTH-1:0]           cnt_q;
    logic signed [CONTROL_WIDTH-1:0] c_q;
    logic [DUTY_WIDTH-1:0]           base_q;
    logic                            mix_vld_q;
    logic                            tdir_l_q, tdir_r_q;
    logic [DUTY_WIDTH-1:0]           tmag_l_q, tmag_r_q;

    logic signed [MIX_W-1:0] base_ext, c_ext, t_l, t_r;

    assign base_ext = {{(MIX_W - DUTY_WIDTH){1'b0}}, base_q};
    assign c_ext    = {{MIX_GUARD{c_q[CONTROL_WIDTH-1]}}, c_q};
    assign t_l      = base_ext + c_ext;
    assign t_r      = base_ext - c_ext;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            c_q       <= '0;
            base_q    <= '0;
            mix_vld_q <= 1'b0;
            tdir_l_q  <= 1'b0;
            tdir_r_q  <= 1'b0;
            tmag_l_q  <= '0;
            tmag_r_q  <= '0;
        end else begin
            if (clk_en_i) begin
                cnt_q <= cnt_q + DUTY_WIDTH'(1);
            end
            if (!en_i) begin
                mix_vld_q <= 1'b0;
                tdir_l_q  <= 1'b0;
                tdir_r_q  <= 1'b0;
                tmag_l_q  <= '0;
                tmag_r_q  <= '0;
            end else begin
                mix_vld_q <= control_valid_i;
                if (control_valid_i) begin
                    c_q    <= control_in_i >>> CTRL_SHIFT;
                    base_q <= base_speed_i;
                end
                // Targets move only on a fresh sample, so re-enabling needs a new one.
                if (mix_vld_q) begin
                    tdir_l_q <= t_l[MIX_W-1];
                    tdir_r_q <= t_r[MIX_W-1];
                    tmag_l_q <= DUTY_WIDTH'(sat_duty(32'(t_l), DUTY_WIDTH));
                    tmag_r_q <= DUTY_WIDTH'(sat_duty(32'(t_r), DUTY_WIDTH));
                end
            end
        end
    end

    assign period_start_o = clk_en_i && (cnt_q == '1);

    motor_channel #(
        .DUTY_WIDTH  (DUTY_WIDTH),
        .DEAD_PERIODS(DEAD_PERIODS),
        .SLEW_STEP   (SLEW_STEP)
    ) u_left (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .en_i          (en_i),
        .period_start_i(period_start_o),
        .cnt_i         (cnt_q),
        .req_dir_i     (tdir_l_q),
        .req_mag_i     (tmag_l_q),
        .pwm_o         (pwm_left_o),
        .dir_o         (dir_left_o),
        .duty_o        (duty_left_o)
    );

    motor_channel #(
        .DUTY_WIDTH  (DUTY_WIDTH),
        .DEAD_PERIODS(DEAD_PERIODS),
        .SLEW_STEP   (SLEW_STEP)
    ) u_right (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .en_i          (en_i),
        .period_start_i(period_start_o),
        .cnt_i         (cnt_q),
        .req_dir_i     (tdir_r_q),
        .req_mag_i     (tmag_r_q),
        .pwm_o         (pwm_right_o),
        .dir_o         (dir_right_o),
        .duty_o        (duty_right_o)
    );

endmodule

// File: doc/motor_pwm_mixer.md
# motor_pwm_mixer

Differential-drive actuator stage for the wall follower. Consumes the signed PID correction and a base speed, mixes them into left/right wheel commands, saturates them, and generates two PWM outputs with direction pins and dead-time protection on direction reversal. Its `period_start` strobe also serves as the PID controller's `clk_en`, so each PID update lines up with a PWM period.

## Interface
- `CONTROL_WIDTH`, 16: width of signed `control_in`.
- `DUTY_WIDTH`, 8: PWM counter and duty width; a period is 2^DUTY_WIDTH ticks.
- `CTRL_SHIFT`, 0: arithmetic right shift applied to `control_in` before mixing.
- `DEAD_PERIODS`, 2: number of whole PWM periods with the output forced low on a direction reversal (≥1).
- `SLEW_STEP`, 16: maximum duty change per period; used only with `MOTOR_PWM_SLEW_EN`.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `clk_en`  in  1: PWM tick enable; the counter advances only on `clk` edges with `clk_en`=1.
- `en`  in  1: block enable.
- `control_in`  in  signed CONTROL_WIDTH: PID correction.
- `control_valid`  in  1: sample strobe for `control_in` and `base_speed`.
- `base_speed`  in  unsigned DUTY_WIDTH: common forward speed.
- `pwm_left`, `pwm_right`  out  1: PWM drive outputs.
- `dir_left`, `dir_right`  out  1: direction; 0 = forward, 1 = reverse.
- `period_start`  out  1: one-`clk` pulse on the tick where the counter wraps to 0.
- `duty_left`, `duty_right`  out  DUTY_WIDTH: applied duty, for debug.

## Operation
- **Sampling.** On `clk` with `en`=1 and `control_valid`=1, latch `c = control_in >>> CTRL_SHIFT` and `base_speed`.
- **Mixing.** On the next `clk`, register the targets, computed at CONTROL_WIDTH+2 signed bits:
  - `t_l = base + c`
  - `t_r = base − c`
- **Saturation.** Clamp each target to ±(2^DUTY_WIDTH−1).
  - Target sign gives the requested direction; magnitude gives the requested duty.
- **Counter.** 0..2^DUTY_WIDTH−1, wrapping.
  - `pwm_x` = (`cnt` < `duty_x`) and the channel is in RUN.
  - Max duty 255 gives 255/256 high.
- **Apply point.** Targets are applied only at a period start, so there are no mid-period glitches.
- **Per-channel FSM** (states RUN, DEAD), evaluated at each period start:
  - **RUN, target magnitude 0:** duty←0, dir holds.
  - **RUN, requested dir == dir:** duty←magnitude.
  - **RUN, requested dir ≠ dir and magnitude ≠ 0:** duty←0, dead_cnt←DEAD_PERIODS, go to DEAD.
  - **DEAD:** decrement dead_cnt at each period start. When it would reach 0: dir←the requested dir at that moment, duty←its magnitude, go to RUN.
  - A reversal that is cancelled during DEAD still completes the full dead time.
- **`en`=0:**
  - `pwm_*` forced 0 combinationally on the next `clk`.
  - Targets cleared to 0, FSMs forced to RUN with duty 0, dir held.
  - Counter and `period_start` keep running.
  - Re-enabling takes effect at the next period start.
- **Simultaneous `control_valid` and period start:** the apply step uses the previously registered targets; the new sample applies a period later.

## Timing
- **Reset values:** all outputs 0, counter 0, both FSMs RUN, targets 0.
- **Latency, sample to target register:** 2 `clk`.
- **Target to output:** at the next period start (0 to 2^DUTY_WIDTH ticks).
- **Reversal:** exactly DEAD_PERIODS full periods with `pwm_x`=0. `dir_x` changes on the same `clk` that the new duty takes effect.
- **`period_start`:** high for exactly one `clk`, coincident with the `clk_en` tick where `cnt` becomes 0.
- **Reset mid-period:** immediate return to the reset values; no dead time is owed after release.

## Configuration
- **`MOTOR_PWM_SLEW_EN` defined:** at each period start, duty moves toward the target magnitude by at most SLEW_STEP.
  - On a reversal, duty first ramps to 0 in RUN, then enters DEAD, then ramps up from 0.
- **`MOTOR_PWM_SLEW_EN` undefined:** duty jumps directly to the target; SLEW_STEP is ignored.

## Structure
- **`motor_pwm_pkg`** holds:
  - `typedef enum logic {RUN, DEAD} motor_state_t`
  - the saturation function `sat_duty`
  - the localparam for the mix width
- **`motor_channel`** is a sub-module holding the FSM, dead counter, slew logic and comparator. It is instantiated twice (left and right) and takes the shared counter and `period_start`.

## Test plan
- **Reset:** assert `reset` mid-period → all outputs 0 within the same cycle; counter restarts at 0 after release.
- **Mixing:** base=100, control=+20 → after the next period start, `duty_left`=120 and `duty_right`=80; `pwm_left` high for 120 of 256 ticks; both dir 0.
- **Saturation:** base=200, control=+100 → left 255 fwd, right 100 fwd. Then base=0, control=−32768 → left reverses to 255 after the dead time; right stays 255 fwd.
- **Reversal:** left target +50 → −50 with DEAD_PERIODS=2 → `pwm_left` low for 2 full periods; `dir_left`=1 and duty 50 at the third period start.
- **Enable:** `en` dropped mid-period → `pwm_*`=0 on the next `clk`, dir held; `en` raised with a new sample → outputs resume at the following period start.
- **Slew** (`MOTOR_PWM_SLEW_EN`, SLEW_STEP=16): target 0→100 → duty 16, 32, 48, 64, 80, 96, 100 on successive periods.
